// File: rtl/rom_scramble_reader.sv
// Reads a contiguous range of ROM words and writes each byte, bit-scrambled, to a destination RAM.
// It also keeps a running XOR checksum of the written data.
module rom_scramble_reader #(
  parameter int Depth = 5,
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [Depth-1:0] base_i,
  input  logic [Depth-1:0] dst_i,
  input  logic [Depth:0]   count_i,
  output logic             rom_cs_no,
  output logic             rom_oe_o,
  output logic [Depth-1:0] rom_addr_o,
  input  logic [Width-1:0] rom_data_i,
  output logic             wr_en_o,
  output logic [Depth-1:0] wr_addr_o,
  output logic [Width-1:0] wr_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] sum_o
);

  typedef enum logic [2:0] {IDLE, SETUP, READ, WRITE, DONE} state_t;

  state_t           state_q, state_d;
  logic [Depth-1:0] base_q, dst_q;
  logic [Depth:0]   count_q, index_q, index_next;
  logic [Width-1:0] data_q, sum_q, scrambled;
  logic             rom_active;

  assign index_next = index_q + {{Depth{1'b0}}, 1'b1};
  assign scrambled  = {data_q[0], data_q[7], data_q[1], data_q[6],
                       data_q[2], data_q[5], data_q[3], data_q[4]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_i) state_d = (count_i == '0) ? DONE : SETUP;
      SETUP: state_d = READ;
      READ:  state_d = WRITE;
      WRITE: state_d = (index_next == count_q) ? DONE : SETUP;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Job parameters are latched only on an accepted start, so later input changes are harmless.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q  <= '0;
      dst_q   <= '0;
      count_q <= '0;
      index_q <= '0;
      data_q  <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          base_q  <= base_i;
          dst_q   <= dst_i;
          count_q <= count_i;
          index_q <= '0;
          sum_q   <= '0;
        end
        READ:  data_q <= rom_data_i;
        WRITE: begin
          sum_q   <= sum_q ^ scrambled;
          index_q <= index_next;
        end
        default: ;
      endcase
    end
  end

  // Addresses wrap modulo 2^Depth by truncating the index.
  assign rom_active = (state_q == SETUP) || (state_q == READ);
  assign rom_cs_no  = ~rom_active;
  assign rom_oe_o   = rom_active;
  assign rom_addr_o = base_q + index_q[Depth-1:0];
  assign wr_en_o    = (state_q == WRITE);
  assign wr_addr_o  = dst_q + index_q[Depth-1:0];
  assign wr_data_o  = scrambled;
  assign busy_o     = rom_active || (state_q == WRITE);
  assign done_o     = (state_q == DONE);
  assign sum_o      = sum_q;

endmodule

// File: tb/tb_rom_scramble_reader.sv
// Self-checking bench for rom_scramble_reader: a ROM model drives read data and a scoreboard
// holds the expected ROM accesses, writes and done pulses with their exact cycle numbers.
module tb_rom_scramble_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] base = '0, dst = '0;
  logic [5:0] count = '0;
  logic       rom_cs_n, rom_oe, wr_en, busy, done;
  logic [4:0] rom_addr, wr_addr;
  logic [7:0] rom_data, wr_data, sum;

  logic [7:0] rom [32];
  assign rom_data = rom[rom_addr];

  rom_scramble_reader #(.Depth(5), .Width(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_i(base), .dst_i(dst),
    .count_i(count), .rom_cs_no(rom_cs_n), .rom_oe_o(rom_oe), .rom_addr_o(rom_addr),
    .rom_data_i(rom_data), .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy), .done_o(done), .sum_o(sum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t wr_q[$];
  ev_t rd_q[$];
  int  done_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] scramble(input logic [7:0] d);
    return {d[0], d[7], d[1], d[6], d[2], d[5], d[3], d[4]};
  endfunction

  // Scoreboard model: t0 is chosen so that the cycle right after the accept edge is t0+1.
  task automatic push_job(input int t0, input logic [4:0] b, input logic [4:0] d,
                          input logic [5:0] n, output logic [7:0] s);
    logic [4:0] ra, wa;
    s = '0;
    for (int k = 0; k < int'(n); k++) begin
      ra = b + 5'(k);
      wa = d + 5'(k);
      rd_q.push_back('{t0 + 3*k + 1, ra, 8'h00});
      rd_q.push_back('{t0 + 3*k + 2, ra, 8'h00});
      wr_q.push_back('{t0 + 3*k + 3, wa, scramble(rom[ra])});
      s ^= scramble(rom[ra]);
    end
    done_q.push_back(t0 + 3*int'(n) + 1);
  endtask

  task automatic start_job(input logic [4:0] b, input logic [4:0] d, input logic [5:0] n,
                           input bit hold, output int t0);
    @(negedge clk);
    base  = b;
    dst   = d;
    count = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input logic [7:0] exp_sum);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (done_q.size() == 0) break;
    end
    check({tag, "_done_pending"}, done_q.size(), 0);
    check({tag, "_wr_pending"}, wr_q.size(), 0);
    check({tag, "_rd_pending"}, rd_q.size(), 0);
    wr_q.delete();
    rd_q.delete();
    done_q.delete();
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, rom_cs_n, 1);
    check({tag, "_oe"}, rom_oe, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sum"}, sum, 0);
  endtask

  // Monitor: every DUT event must match the head of its queue, in the exact cycle.
  always @(negedge clk) begin
    ev_t e;
    int  dc;
    if (!rst) begin
      if (wr_en === 1'b1) begin
        if (wr_q.size() == 0) check("extra_wr", wr_en, 0);
        else begin
          e = wr_q.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
          check("wr_cs_n", rom_cs_n, 1);
          check("wr_oe", rom_oe, 0);
          check("wr_busy", busy, 1);
        end
      end
      if (rom_cs_n === 1'b0) begin
        if (rd_q.size() == 0) check("extra_rom_access", rom_cs_n, 1);
        else begin
          e = rd_q.pop_front();
          check("rd_cycle", cyc, e.cyc);
          check("rd_addr", rom_addr, e.addr);
          check("rd_oe", rom_oe, 1);
          check("rd_busy", busy, 1);
        end
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) check("extra_done", done, 0);
        else begin
          dc = done_q.pop_front();
          check("done_cycle", cyc, dc);
          check("done_busy", busy, 0);
        end
      end
    end
  end

  initial begin
    int t0, t1;
    logic [7:0] s1, s2;

    for (int i = 0; i < 32; i++) rom[i] = 8'(i * 37 + 11);
    rom[5'h10] = 8'hDA;
    rom[5'h11] = 8'h7E;
    rom[5'h1E] = 8'h33;

    #2 rst = 1'b1;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] known ROM image job");
    start_job(5'h10, 5'h00, 6'd2, 1'b0, t0);
    push_job(t0, 5'h10, 5'h00, 6'd2, s1);
    check("model_sum_image", {24'h0, s1}, 32'h4C);
    wait_idle("image", 8'h4C);

    $display("[TB] zero-count job");
    start_job(5'h07, 5'h03, 6'd0, 1'b0, t0);
    push_job(t0, 5'h07, 5'h03, 6'd0, s1);
    wait_idle("zero", 8'h00);

    $display("[TB] wrap-around job");
    start_job(5'h1E, 5'h1F, 6'd4, 1'b0, t0);
    push_job(t0, 5'h1E, 5'h1F, 6'd4, s1);
    wait_idle("wrap", s1);

    $display("[TB] start pulsed while busy");
    start_job(5'h04, 5'h08, 6'd3, 1'b0, t0);
    push_job(t0, 5'h04, 5'h08, 6'd3, s1);
    while (cyc < t0 + 4) @(negedge clk);
    base  = 5'h1A;
    dst   = 5'h02;
    count = 6'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy_start", s1);

    $display("[TB] reset during READ of word 3");
    start_job(5'h00, 5'h10, 6'd8, 1'b0, t0);
    push_job(t0, 5'h00, 5'h10, 6'd8, s1);
    while (cyc < t0 + 11) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midjob");
    check("midjob_wr_left", wr_q.size(), 5);
    wr_q.delete();
    rd_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_reset_sum", sum, 0);

    $display("[TB] back-to-back with start held high");
    start_job(5'h10, 5'h04, 6'd2, 1'b1, t0);
    push_job(t0, 5'h10, 5'h04, 6'd2, s1);
    t1 = t0 + 3*2 + 2;
    push_job(t1, 5'h10, 5'h04, 6'd2, s2);
    for (int i = 0; i < 50 && cyc < t1 + 1; i++) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_idle("b2b", s2);

    $display("[TB] full-range copy");
    start_job(5'h00, 5'h00, 6'd32, 1'b0, t0);
    push_job(t0, 5'h00, 5'h00, 6'd32, s1);
    wait_idle("full", s1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rom_scramble_reader.md
# rom_scramble_reader

Bus-initiator block that reads a contiguous range of words from the lab ROM through its chip-select / output-enable / address port. Each byte is bit-scrambled and written to a destination RAM write port. A running XOR checksum of the written data is kept. The block is the reading end of the ROM interface: it replaces bench-driven ROM reads with a clocked controller that can sit between the ROM and a shadow RAM.

## Interface
Parameters:
- Depth, 5, address width in bits for both ROM and destination (2^Depth words)
- Width, 8, data width; fixed at 8 because the scramble map is byte-defined

Ports:
- clk_i  in  1  rising-edge clock
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  starts a job when sampled high in IDLE
- base_i  in  Depth  first ROM address of the job
- dst_i  in  Depth  first destination address of the job
- count_i  in  Depth+1  number of words to move, 0..2^Depth
- rom_cs_no  out  1  ROM chip select, active low
- rom_oe_o  out  1  ROM output enable, active high
- rom_addr_o  out  Depth  ROM address
- rom_data_i  in  Width  ROM read data (combinational from the ROM)
- wr_en_o  out  1  destination write strobe, one cycle per word
- wr_addr_o  out  Depth  destination address
- wr_data_o  out  Width  scrambled write data
- busy_o  out  1  high while a job is in progress
- done_o  out  1  one-cycle pulse at job end
- sum_o  out  Width  XOR of all bytes written in the current/last job

## Operation
- Scramble map: out = {d[0], d[7], d[1], d[6], d[2], d[5], d[3], d[4]} (MSB first).
- FSM states: IDLE, SETUP, READ, WRITE, DONE.
- IDLE: when start_i=1, latch base_i, dst_i, count_i; clear the index and sum_o.
  - If count_i=0, go to DONE; otherwise go to SETUP.
- SETUP: rom_cs_no=0, rom_oe_o=1, rom_addr_o = base+index. Go to READ (a settle cycle).
- READ: same ROM drive as SETUP. On the exit edge, capture rom_data_i into the data register. Go to WRITE.
- WRITE:
  - rom_cs_no=1, rom_oe_o=0.
  - wr_en_o=1, wr_addr_o = dst+index, wr_data_o = scramble(captured).
  - On exit: sum_o ^= wr_data_o and index += 1.
  - If index+1 == count, go to DONE; else go to SETUP.
- DONE: done_o=1 for one cycle; busy_o=0. Go to IDLE.
- Address arithmetic is modulo 2^Depth. base+index and dst+index wrap silently (e.g., base=0x1E, count=4 reads 0x1E,0x1F,0x00,0x01).
- start_i outside IDLE is ignored; a job cannot be restarted or aborted except by rst_i.
- Input ports base_i/dst_i/count_i may change after the start edge without effect.
- sum_o holds its value after DONE until the next accepted start.
- busy_o = 1 in SETUP, READ, WRITE.

## Timing
- Reset (asynchronous, immediate): state=IDLE, rom_cs_no=1, rom_oe_o=0, rom_addr_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, done_o=0, sum_o=0.
- Reset mid-job: outputs take reset values immediately. No further writes occur, and no done_o pulse is issued for the aborted job.
- All outputs are registered except where decoded directly from state; no combinational path from rom_data_i to any output.
- Call the start-accept edge edge 0. Word k (k = 0..N-1) then occupies:
  - SETUP in cycle 3k+1
  - READ in cycle 3k+2
  - WRITE in cycle 3k+3
- done_o is high in cycle 3N+1; busy_o is low from that cycle.
- count=0: done_o is high in cycle 1; no ROM access and no write.
- Back-to-back: start_i held high through DONE is accepted on the first IDLE edge, i.e. 2 cycles after done_o rises.
- rom_data_i must be stable by the end of READ (2 cycles after the address is driven).

## Test plan
- Reset mid-job: assert rst_i during the READ of word 3.
  - All outputs return to reset values asynchronously.
  - No wr_en_o afterwards, no done_o pulse.
  - A new start then runs normally.
- ROM preloaded from the standard hex image (0x10=DA, 0x11=7E); base=0x10, dst=0x00, count=2.
  - Writes (0x00, 0x73) in cycle 3 and (0x01, 0x3F) in cycle 6.
  - done_o in cycle 7; sum_o=0x4C.
- count=0 with start_i=1: done_o in cycle 1, rom_cs_no stays 1, no wr_en_o, sum_o=0.
- Wrap-around: base=0x1E, dst=0x1F, count=4.
  - ROM addresses 1E,1F,00,01.
  - Write addresses 1F,00,01,02.
  - Data = scrambled 0x33, 0xXX-loc, etc., checked against a reference model.
  - done_o in cycle 13.
- Full-range copy: count=32 with all ROM words defined.
  - 32 writes, each exactly 3 cycles apart.
  - rom_cs_no/rom_oe_o deasserted in every WRITE cycle.
  - done_o in cycle 97.
- start_i pulsed again during busy: ignored; latched base/count are unchanged and the write sequence is identical to the single-start run.
